mprj_uart_tx: RTL and testbench
===============================

Name: mprj_uart_tx

Overview:
- 8N1 UART transmitter in the user project area, driving the status/console line mprj_io[6] that the bench UART monitor (tbuart) samples.
- Firmware or LA-driven logic pushes bytes through a valid/ready port into a small FIFO.
- Bytes are serialised LSB-first at a fixed clock-divided bit rate.
- It is the transmit end of the same serial link the testbench receives on.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per serial bit (40 MHz / 115200). Minimum 2.
- FIFO_DEPTH, 4, byte FIFO entries. Power of two, minimum 2.
- ADDR_W, $clog2(FIFO_DEPTH), derived pointer width. Not overridden.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetb  in  1  synchronous, active-low reset.
- enable  in  1  when 0, no new frame starts; a frame in progress completes.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept; a push occurs on an edge where in_valid && in_ready.
- tx  out  1  serial line, idle high; routed to mprj_io[6].
- busy  out  1  frame in progress or FIFO non-empty.
- tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_count  out  ADDR_W+1  bytes currently queued, 0..FIFO_DEPTH.

Behaviour:
- Reset (resetb==0 at an edge) sets the following, regardless of the state before reset:
  - tx=1, in_ready=1, busy=0, tx_done=0, fifo_count=0.
  - FIFO pointers cleared, state=IDLE, baud counter=0, bit counter=0.
- Reset mid-frame aborts the frame; tx returns high after that edge.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - A push and a pop on the same edge are both legal; fifo_count is unchanged.
  - When full, in_ready=0 and in_valid is ignored; the data is not lost from the source's perspective.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE:
  - tx=1.
  - If enable && FIFO non-empty: pop the head into an 8-bit shift register, go to START, clear the baud counter.
- Each of START, DATA-bit, STOP lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1.
- Line levels per state:
  - START: tx=0.
  - DATA: tx = shift[0]; shift right at each bit end; 8 bits, bit counter 0..7.
  - STOP: tx=1.
- Latency: byte pushed at edge k into an empty FIFO with state IDLE and enable=1 → popped at edge k+1 → tx low from edge k+1 for CLKS_PER_BIT cycles.
- Frame length is 10*CLKS_PER_BIT cycles.
- End of STOP:
  - tx_done=1 for that cycle.
  - If enable && FIFO non-empty: pop and go directly to START on the same edge; there is no idle cycle between frames.
  - Otherwise go to IDLE.
- enable deasserted mid-frame has no effect until the frame ends.
- busy = (state != IDLE) || (fifo_count != 0).
- tx is driven from a register; no combinational path from inputs to tx.

Optional Feature:
- Macro: MPRJ_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = XOR of the 8 data bits (even parity), computed at pop.
  - Frame length is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold resetb=0 for 3 edges → tx=1, in_ready=1, busy=0, fifo_count=0, tx_done=0; release with no push → outputs unchanged for 100 cycles.
- Single byte 0xA5 pushed at edge k → tx=0 on cycles k+1..k+4, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles. tx_done high exactly at cycle k+40; busy falls after it.
- Burst: push 0x01..0x06 with in_valid held high from edge k:
  - 0x01..0x05 are accepted on edges k..k+4; in_ready=0 from k+5 with fifo_count=4.
  - 0x06 is accepted one cycle after the first tx_done.
  - Six contiguous frames, 240 cycles, no idle-high gap between stop and start.
- enable=0, push 0x3C, 0x3C → tx stays 1 and fifo_count=2 for 200 cycles. Raise enable → start bit on the next edge; both frames sent back-to-back.
- Reset mid-frame: push 0xFF, assert resetb=0 during DATA bit 3 → next edge tx=1, fifo_count=0, busy=0. After release, no residual frame is emitted.
- With MPRJ_UART_TX_PARITY_EN: byte 0x07 → parity bit 1; byte 0x03 → parity bit 0. Frame 44 cycles; tx_done at cycle k+44.

Source files
------------

// File: rtl/mprj_uart_tx.sv
// ---------------------------------------------------------------------------
// mprj_uart_tx
//
// 8N1 UART transmitter for the user project area. Bytes arrive through a
// valid/ready port into a small FIFO and are sent LSB-first on the serial
// line routed to mprj_io[6], at a fixed clock-divided bit rate.
//
// Optional build macro:
//   MPRJ_UART_TX_PARITY_EN - inserts an even-parity bit between the last
//                            data bit and the stop bit (8E1 framing).
//
// Ports:
//   clock      - system clock, all logic on the rising edge
//   resetb     - synchronous active-low reset
//   enable     - gates the start of new frames; a running frame completes
//   in_data    - byte to transmit
//   in_valid   - in_data is valid
//   in_ready   - FIFO can accept; push when in_valid && in_ready
//   tx         - registered serial line, idle high
//   busy       - frame in progress or FIFO non-empty
//   tx_done    - one-cycle pulse on the last cycle of each stop bit
//   fifo_count - bytes currently queued, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module mprj_uart_tx #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              enable,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef MPRJ_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [BAUD_W-1:0]   baud_q;
    logic [BAUD_W-1:0]   baud_d;
    logic [2:0]          bit_q;
    logic [2:0]          bit_d;
    logic [7:0]          shift_q;
    logic [7:0]          shift_d;
    logic                tx_q;
    logic                tx_d;
`ifdef MPRJ_UART_TX_PARITY_EN
    logic                parity_q;
    logic                parity_d;
`endif

    logic [7:0]          mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_q;

    logic                push;
    logic                pop;
    logic                bit_end;
    logic                can_start;

    // Handshake and status come straight from registered state so that the
    // source sees a stable in_ready for the whole cycle.
    assign in_ready   = (count_q != COUNT_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign tx_done    = (state_q == STOP) && bit_end;
    assign tx         = tx_q;

    assign bit_end    = (baud_q == BAUD_LAST);
    assign can_start  = enable && (count_q != '0);

    // Next-state logic. A new frame is fetched either from IDLE or on the
    // very last stop-bit cycle, so back-to-back frames have no idle gap.
    // The line level is derived from the next state so tx can be a plain
    // register that already shows the start bit on the popping edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        tx_d     = 1'b1;
`ifdef MPRJ_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef MPRJ_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef MPRJ_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (can_start) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        if (pop) begin
            shift_d  = mem[rd_ptr];
`ifdef MPRJ_UART_TX_PARITY_EN
            parity_d = ^mem[rd_ptr];
`endif
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef MPRJ_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, line register and FIFO bookkeeping. Reset aborts any
    // frame in flight and discards queued bytes.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
`ifdef MPRJ_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef MPRJ_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage has no reset; only entries between the pointers matter.
    always_ff @(posedge clock) begin
        if (resetb && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_mprj_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mprj_uart_tx
//
// Self-checking bench for mprj_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The reference model keeps the queued bytes and the expected future line
// waveform as queues: when the line is free (or on its last stop cycle) and
// transmission is enabled, the head byte is expanded into its frame bits.
// Honours MPRJ_UART_TX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mprj_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MPRJ_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    bit         wave[$];
    logic [7:0] mFifo[$];

    mprj_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expand one byte into its serial frame, each bit held CPB cycles.
    task automatic appendFrame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef MPRJ_UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int c = 0; c < CPB; c++) wave.push_back(bits[j]);
        end
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic modelEdge();
        int  cnt;
        bit  accept;
        bit  ending;
        cnt    = mFifo.size();
        accept = (in_valid === 1'b1) && (cnt < DEPTH);
        if (resetb === 1'b0) begin
            mFifo.delete();
            wave.delete();
            return;
        end
        ending = (wave.size() <= 1);
        if (wave.size() > 0) void'(wave.pop_front());
        if (ending && (enable === 1'b1) && (cnt > 0)) appendFrame(mFifo.pop_front());
        if (accept) mFifo.push_back(in_data);
    endtask

    task automatic checkOutput(input string tag);
        logic expTx;
        expTx = (wave.size() > 0) ? wave[0] : 1'b1;
        checkVal({tag, "/tx"},       tx,         expTx);
        checkVal({tag, "/tx_done"},  tx_done,    (wave.size() == 1));
        checkVal({tag, "/busy"},     busy,       (wave.size() > 0) || (mFifo.size() > 0));
        checkVal({tag, "/in_ready"}, in_ready,   (mFifo.size() < DEPTH));
        checkVal({tag, "/count"},    fifo_count, mFifo.size());
    endtask

    // Drive inputs for one cycle, cross the edge, then compare outputs.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic en,
                                 input logic rb, input string tag);
        in_valid = v;
        in_data  = d;
        enable   = en;
        resetb   = rb;
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    // Push one byte into an idle transmitter and record the line level in
    // the middle of each bit plus the cycle of the first tx_done.
    task automatic runFrame(input logic [7:0] b, input string tag,
                            output int doneAt, output logic [15:0] levels);
        doneAt = -1;
        levels = '1;
        applyStimulus(1'b1, b, 1'b1, 1'b1, {tag, "_push"});
        for (int i = 1; i <= FRAME_CYC + 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, tag);
            if (tx_done === 1'b1 && doneAt < 0) doneAt = i;
            if (i >= 2 && ((i - 2) % CPB) == 0 && ((i - 2) / CPB) < FRAME_BITS)
                levels[(i - 2) / CPB] = tx;
        end
    endtask

    initial begin
        int          doneAt;
        logic [15:0] levels;
        int          a5Levels[FRAME_BITS];
        int          idx;
        int          acceptCyc[7];
        int          firstDone;
        int          lastDone;
        int          doneCount;
        bit          accept;
        bit          sawLow;
        bit          drained;

`ifdef MPRJ_UART_TX_PARITY_EN
        a5Levels = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        a5Levels = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

        in_valid = 1'b0;
        in_data  = 8'h00;
        enable   = 1'b1;
        resetb   = 1'b0;

        // Reset held for three edges, then a quiet idle period.
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "reset");
        checkVal("reset_tx", tx, 1);
        checkVal("reset_in_ready", in_ready, 1);
        checkVal("reset_busy", busy, 0);
        checkVal("reset_count", fifo_count, 0);
        checkVal("reset_tx_done", tx_done, 0);
        repeat (100) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "idle");

        // Single byte 0xA5.
        runFrame(8'hA5, "a5", doneAt, levels);
        checkVal("a5_done_cycle", doneAt, FRAME_CYC);
        for (int j = 0; j < FRAME_BITS; j++)
            checkVal($sformatf("a5_bit%0d", j), levels[j], a5Levels[j]);
        checkVal("a5_busy_after", busy, 0);

        // Burst of six bytes with in_valid held high.
        idx       = 1;
        firstDone = -1;
        lastDone  = -1;
        doneCount = 0;
        foreach (acceptCyc[i]) acceptCyc[i] = -1;
        for (int c = 0; c < 6 * FRAME_CYC + 20; c++) begin
            accept = (idx <= 6) && (mFifo.size() < DEPTH);
            applyStimulus(idx <= 6, 8'(idx), 1'b1, 1'b1, "burst");
            if (accept) begin
                acceptCyc[idx] = c;
                idx++;
            end
            if (tx_done === 1'b1) begin
                if (firstDone < 0) firstDone = c;
                lastDone = c;
                doneCount++;
            end
            if (c == 4) begin
                checkVal("burst_full_count", fifo_count, DEPTH);
                checkVal("burst_full_ready", in_ready, 0);
            end
            if (c == FRAME_CYC) checkVal("burst_ready_at_done", in_ready, 0);
            if (c == FRAME_CYC + 1) checkVal("burst_ready_after_done", in_ready, 1);
        end
        checkVal("burst_accept_05", acceptCyc[5], 4);
        checkVal("burst_first_done", firstDone, FRAME_CYC);
        checkVal("burst_accept_06", acceptCyc[6], FRAME_CYC + 2);
        checkVal("burst_last_done", lastDone, 6 * FRAME_CYC);
        checkVal("burst_done_count", doneCount, 6);
        checkVal("burst_idle_after", busy, 0);

        // Bytes queued while disabled stay queued until enable rises.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, "en_off_push");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, "en_off_push");
        sawLow = 1'b0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "en_off");
            if (tx !== 1'b1) sawLow = 1'b1;
        end
        checkVal("en_off_line_high", sawLow, 0);
        checkVal("en_off_count", fifo_count, 2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "en_on");
        checkVal("en_on_start_bit", tx, 0);
        doneCount = 0;
        for (int c = 0; c < 2 * FRAME_CYC + 10; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "en_on_run");
            if (tx_done === 1'b1) doneCount++;
        end
        checkVal("en_on_done_count", doneCount, 2);
        checkVal("en_on_idle_after", busy, 0);

        // Reset during data bit 3 with a second byte still queued.
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, "mid_push");
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, "mid_push");
        repeat (16) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "mid_run");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "mid_reset");
        checkVal("mid_reset_tx", tx, 1);
        checkVal("mid_reset_count", fifo_count, 0);
        checkVal("mid_reset_busy", busy, 0);
        sawLow = 1'b0;
        for (int c = 0; c < 60; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "post_reset");
            if (tx !== 1'b1) sawLow = 1'b1;
        end
        checkVal("post_reset_no_frame", sawLow, 0);

`ifdef MPRJ_UART_TX_PARITY_EN
        // Even parity over the data bits.
        runFrame(8'h07, "par07", doneAt, levels);
        checkVal("par07_parity", levels[9], 1);
        checkVal("par07_done_cycle", doneAt, 44);
        runFrame(8'h03, "par03", doneAt, levels);
        checkVal("par03_parity", levels[9], 0);
        checkVal("par03_done_cycle", doneAt, 44);
`endif

        // Randomised traffic, enable toggling and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 7) != 0), ($urandom_range(0, 299) != 0),
                          "random");
        end

        // Drain whatever is left, bounded.
        drained = 1'b0;
        for (int c = 0; c < 8 * FRAME_CYC; c++) begin
            if (wave.size() == 0 && mFifo.size() == 0) begin
                drained = 1'b1;
                break;
            end
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "drain");
        end
        checkVal("drain_model_idle", drained, 1);
        checkVal("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
